// File: rtl/fpu_bist_pkg.sv
// Shared types for the FPU BIST controller: FSM states and vector word layout.
// The vector word is {opcode, A, B, expected}, MSB first.
package fpu_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_LAUNCH,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } fpu_bist_state_t;

    typedef enum logic [1:0] {
        F_EXP,
        F_B,
        F_A,
        F_OP
    } fpu_bist_field_t;

    localparam int VEC_OP_W    = 4;
    localparam int VEC_DATA_W  = 32;
    localparam int VEC_EXP_LSB = 0;
    localparam int VEC_B_LSB   = VEC_DATA_W;
    localparam int VEC_A_LSB   = 2 * VEC_DATA_W;
    localparam int VEC_OP_LSB  = 3 * VEC_DATA_W;

    typedef struct packed {
        logic [VEC_OP_W-1:0]   op;
        logic [VEC_DATA_W-1:0] a;
        logic [VEC_DATA_W-1:0] b;
        logic [VEC_DATA_W-1:0] exp;
    } fpu_bist_vec_t;

    // Field LSB for a vector word built from operands of width data_w.
    function automatic int vec_lsb(fpu_bist_field_t f, int data_w);
        case (f)
            F_EXP:   return 0;
            F_B:     return data_w;
            F_A:     return 2 * data_w;
            default: return 3 * data_w;
        endcase
    endfunction

endpackage

// File: rtl/fpu_bist_wdog.sv
// WAIT-cycle watchdog: cleared by load, counts while en, flags the LIMIT-th counted cycle.
// Latency: expired is combinational on the current count; no backpressure.
module fpu_bist_wdog #(
    parameter int LIMIT = 1024,
    localparam int CW = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (en && cnt != CW'(LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/fpu_bist_ctrl.sv
// BIST controller: walks NUM_VEC vectors through the FPU start/done handshake and keeps statistics.
// Latency: 4 + W cycles per vector (W = WAIT cycles incl. done); waits indefinitely on fpu_done
// unless FPU_BIST_TIMEOUT_EN is defined, which adds a TIMEOUT_CYC watchdog on WAIT.
module fpu_bist_ctrl
    import fpu_bist_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int OP_W        = 4,
    parameter int NUM_VEC     = 100,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024,
    localparam int ADDR_W     = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bist_go,
    output logic                     bist_busy,
    output logic                     bist_done,
    output logic [ADDR_W-1:0]        vec_addr,
    input  logic [OP_W+3*DATA_W-1:0] vec_data,
    output logic                     fpu_start,
    output logic [OP_W-1:0]          fpu_opcode,
    output logic [DATA_W-1:0]        fpu_A,
    output logic [DATA_W-1:0]        fpu_B,
    input  logic [DATA_W-1:0]        fpu_result,
    input  logic                     fpu_done,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic [CNT_W-1:0]         timeout_cnt,
    output logic                     first_fail_valid,
    output logic [ADDR_W-1:0]        first_fail_idx,
    output logic [DATA_W-1:0]        first_fail_result
);

    localparam int OP_LSB  = vec_lsb(F_OP, DATA_W);
    localparam int A_LSB   = vec_lsb(F_A, DATA_W);
    localparam int B_LSB   = vec_lsb(F_B, DATA_W);
    localparam int EXP_LSB = vec_lsb(F_EXP, DATA_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    fpu_bist_state_t   state, state_nx;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] exp_r;
    logic [DATA_W-1:0] res_r;
    logic              tmo_hit;
    logic              tmo_seen;

`ifdef FPU_BIST_TIMEOUT_EN
    logic             wd_expired;
    logic             tmo_flag;
    logic [CNT_W-1:0] tmo_r;

    fpu_bist_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .load    (state == ST_LAUNCH),
        .en      (state == ST_WAIT),
        .expired (wd_expired)
    );

    // A done arriving on the expiry cycle still wins.
    assign tmo_hit = wd_expired & ~fpu_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_flag <= 1'b0;
            tmo_r    <= '0;
        end else begin
            if ((state == ST_IDLE || state == ST_DONE) && bist_go) tmo_r <= '0;
            if (state == ST_LAUNCH) tmo_flag <= 1'b0;
            if (state == ST_WAIT && tmo_hit) tmo_flag <= 1'b1;
            if (state == ST_CHECK && tmo_flag && tmo_r != CNT_MAX) tmo_r <= tmo_r + 1'b1;
        end
    end

    assign tmo_seen    = tmo_flag;
    assign timeout_cnt = tmo_r;
`else
    assign tmo_hit     = 1'b0;
    assign tmo_seen    = 1'b0;
    assign timeout_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        bist_busy = 1'b1;
        bist_done = 1'b0;
        fpu_start = 1'b0;
        vec_addr  = idx;
        case (state)
            ST_IDLE: begin
                bist_busy = 1'b0;
                if (bist_go) state_nx = ST_FETCH;
            end
            ST_FETCH:  state_nx = ST_LOAD;
            ST_LOAD:   state_nx = ST_LAUNCH;
            ST_LAUNCH: begin
                fpu_start = 1'b1;
                state_nx  = ST_WAIT;
            end
            ST_WAIT:   if (fpu_done || tmo_hit) state_nx = ST_CHECK;
            ST_CHECK:  state_nx = (idx == LAST_IDX) ? ST_DONE : ST_FETCH;
            ST_DONE: begin
                bist_busy = 1'b0;
                bist_done = 1'b1;
                if (bist_go) state_nx = ST_FETCH;
            end
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx               <= '0;
            fpu_opcode        <= '0;
            fpu_A             <= '0;
            fpu_B             <= '0;
            exp_r             <= '0;
            res_r             <= '0;
            pass_cnt          <= '0;
            fail_cnt          <= '0;
            first_fail_valid  <= 1'b0;
            first_fail_idx    <= '0;
            first_fail_result <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bist_go) begin
                        idx               <= '0;
                        pass_cnt          <= '0;
                        fail_cnt          <= '0;
                        first_fail_valid  <= 1'b0;
                        first_fail_idx    <= '0;
                        first_fail_result <= '0;
                    end
                end
                ST_LOAD: begin
                    fpu_opcode <= vec_data[OP_LSB +: OP_W];
                    fpu_A      <= vec_data[A_LSB +: DATA_W];
                    fpu_B      <= vec_data[B_LSB +: DATA_W];
                    exp_r      <= vec_data[EXP_LSB +: DATA_W];
                end
                ST_WAIT: begin
                    if (fpu_done) res_r <= fpu_result;
                end
                ST_CHECK: begin
                    // Bit-exact compare: no NaN or signed-zero equivalence.
                    if (tmo_seen || res_r != exp_r) begin
                        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
                        if (!first_fail_valid) begin
                            first_fail_valid  <= 1'b1;
                            first_fail_idx    <= idx;
                            first_fail_result <= tmo_seen ? '0 : res_r;
                        end
                    end else if (pass_cnt != CNT_MAX) begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_bist_ctrl.sv
// Bench for fpu_bist_ctrl: directed runs against a responder FPU, run summaries checked by a scoreboard.
module tb_fpu_bist_ctrl;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int NV = 4;
    localparam int AW = 2;
    localparam int CW = 16;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, bist_go, bist_busy, bist_done;
    logic [AW-1:0]         vec_addr;
    logic [OW+3*DW-1:0]    vec_data;
    logic                  fpu_start, fpu_done;
    logic [OW-1:0]         fpu_opcode;
    logic [DW-1:0]         fpu_A, fpu_B, fpu_result;
    logic [CW-1:0]         pass_cnt, fail_cnt, timeout_cnt;
    logic                  first_fail_valid;
    logic [AW-1:0]         first_fail_idx;
    logic [DW-1:0]         first_fail_result;

    fpu_bist_ctrl #(.DATA_W(DW), .OP_W(OW), .NUM_VEC(NV), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .bist_go(bist_go), .bist_busy(bist_busy), .bist_done(bist_done),
        .vec_addr(vec_addr), .vec_data(vec_data), .fpu_start(fpu_start), .fpu_opcode(fpu_opcode),
        .fpu_A(fpu_A), .fpu_B(fpu_B), .fpu_result(fpu_result), .fpu_done(fpu_done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_cnt(timeout_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
        .first_fail_result(first_fail_result)
    );

    // Saturation instance: 5 vectors, 2-bit counters.
    logic                  go2, busy2, done2, start2, fdone2, ffv2;
    logic [2:0]            addr2, ffidx2;
    logic [OW+3*DW-1:0]    data2;
    logic [OW-1:0]         op2;
    logic [DW-1:0]         a2, b2, res2, ffres2;
    logic [1:0]            pass2, fail2, tmo2;

    fpu_bist_ctrl #(.DATA_W(DW), .OP_W(OW), .NUM_VEC(5), .CNT_W(2), .TIMEOUT_CYC(TO)) dut_sat (
        .clk(clk), .rst(rst), .bist_go(go2), .bist_busy(busy2), .bist_done(done2),
        .vec_addr(addr2), .vec_data(data2), .fpu_start(start2), .fpu_opcode(op2),
        .fpu_A(a2), .fpu_B(b2), .fpu_result(res2), .fpu_done(fdone2),
        .pass_cnt(pass2), .fail_cnt(fail2), .timeout_cnt(tmo2),
        .first_fail_valid(ffv2), .first_fail_idx(ffidx2), .first_fail_result(ffres2)
    );

    // Vector memory, 1-cycle read latency.
    logic [OW-1:0] m_op [NV];
    logic [DW-1:0] m_a [NV], m_b [NV], m_e [NV];
    always @(posedge clk) vec_data <= {m_op[vec_addr], m_a[vec_addr], m_b[vec_addr], m_e[vec_addr]};
    always @(posedge clk) data2 <= {4'h0, 29'd0, addr2, 32'd0, 29'd0, addr2};

    // Responder FPU: done on the 3rd WAIT cycle with a per-vector canned result.
    logic [DW-1:0] resp [NV];
    logic          hang [NV];
    logic          stale = 1'b0;
    int            mcnt = 0, mcnt2 = 0;
    logic [AW-1:0] mvec = '0;
    always @(posedge clk) begin
        if (fpu_start) begin
            mcnt <= 1;
            mvec <= vec_addr;
        end else if (mcnt == 3) mcnt <= 0;
        else if (mcnt != 0)     mcnt <= mcnt + 1;
        if (start2)             mcnt2 <= 1;
        else if (mcnt2 == 3)    mcnt2 <= 0;
        else if (mcnt2 != 0)    mcnt2 <= mcnt2 + 1;
    end
    assign fpu_done   = (mcnt == 3 && !hang[mvec]) || stale;
    assign fpu_result = resp[mvec];
    assign fdone2     = (mcnt2 == 3);
    assign res2       = a2 + b2 + {28'd0, op2};

    typedef struct {
        int          pass_n, fail_n, tmo_n, ffv, ffidx, lat;
        logic [31:0] ffres;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0, go_cyc = 0, exp_li = 0;
    logic done_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    // Expected run summary from the responder table; latency counts from the go-sampling cycle.
    function automatic exp_t predict();
        exp_t e;
        e.pass_n = 0; e.fail_n = 0; e.tmo_n = 0; e.ffv = 0; e.ffidx = 0; e.ffres = '0; e.lat = 1;
        for (int i = 0; i < NV; i++) begin
            e.lat += 4 + (hang[i] ? TO : 3);
            if (!hang[i] && resp[i] == m_e[i]) e.pass_n++;
            else begin
                e.fail_n++;
                if (hang[i]) e.tmo_n++;
                if (e.ffv == 0) begin
                    e.ffv = 1; e.ffidx = i; e.ffres = hang[i] ? 32'h0 : resp[i];
                end
            end
        end
        return e;
    endfunction

    // Monitor: launched operands in order, and run summary on each bist_done rise.
    always @(negedge clk) begin
        exp_t e;
        if (!bist_busy) exp_li = 0;
        else if (fpu_start) begin
            chk("launch_idx", 32'(vec_addr), 32'(exp_li));
            chk("launch_op", 32'(fpu_opcode), 32'(m_op[exp_li % NV]));
            chk("launch_A", fpu_A, m_a[exp_li % NV]);
            chk("launch_B", fpu_B, m_b[exp_li % NV]);
            exp_li++;
        end
        if (bist_done && !done_q) begin
            if (sb_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_done: got bist_done=1, required no completion");
            end else begin
                e = sb_q.pop_front();
                chk("pass_cnt", 32'(pass_cnt), 32'(e.pass_n));
                chk("fail_cnt", 32'(fail_cnt), 32'(e.fail_n));
                chk("timeout_cnt", 32'(timeout_cnt), 32'(e.tmo_n));
                chk("ff_valid", 32'(first_fail_valid), 32'(e.ffv));
                chk("ff_idx", 32'(first_fail_idx), 32'(e.ffidx));
                chk("ff_result", first_fail_result, e.ffres);
                chk("done_latency", 32'(cyc - go_cyc), 32'(e.lat));
            end
        end
        done_q = bist_done;
    end

    task automatic set_all_pass();
        for (int i = 0; i < NV; i++) begin
            resp[i] = m_e[i];
            hang[i] = 1'b0;
        end
    endtask

    task automatic go_pulse();
        @(negedge clk);
        bist_go = 1'b1;
        go_cyc  = cyc;
        @(negedge clk);
        bist_go = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bist_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!bist_done) begin
            n_tests++; n_fail++;
            $display("FAIL %s: bist_done=0 after %0d cycles, required 1", name, n);
        end
    endtask

    task automatic wait_launch(input int k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(fpu_start && 32'(vec_addr) == k) && n < 500);
        if (!(fpu_start && 32'(vec_addr) == k)) begin
            n_tests++; n_fail++;
            $display("FAIL launch_wait: no launch of vector %0d within %0d cycles", k, n);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctl"}, {26'd0, bist_busy, bist_done, fpu_start, first_fail_valid, vec_addr}, 32'h0);
        chk({name, "_ffidx"}, 32'(first_fail_idx), 32'h0);
        chk({name, "_op"}, 32'(fpu_opcode), 32'h0);
        chk({name, "_A"}, fpu_A, 32'h0);
        chk({name, "_B"}, fpu_B, 32'h0);
        chk({name, "_cnts"}, {pass_cnt, fail_cnt}, 32'h0);
        chk({name, "_tmo"}, 32'(timeout_cnt), 32'h0);
        chk({name, "_ffres"}, first_fail_result, 32'h0);
    endtask

    initial begin
        rst = 1'b1; bist_go = 1'b0; go2 = 1'b0;
        // 0+0, 1+2=3, 5-2=3, 2*3=6 in IEEE single.
        m_op[0] = 4'h0; m_a[0] = 32'h00000000; m_b[0] = 32'h00000000; m_e[0] = 32'h00000000;
        m_op[1] = 4'h0; m_a[1] = 32'h3f800000; m_b[1] = 32'h40000000; m_e[1] = 32'h40400000;
        m_op[2] = 4'h1; m_a[2] = 32'h40a00000; m_b[2] = 32'h40000000; m_e[2] = 32'h40400000;
        m_op[3] = 4'h2; m_a[3] = 32'h40000000; m_b[3] = 32'h40400000; m_e[3] = 32'h40c00000;
        set_all_pass();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // All-pass run.
        sb_q.push_back(predict());
        go_pulse();
        wait_done("all_pass");
        repeat (3) @(negedge clk);
        chk("done_hold", 32'(bist_done), 32'd1);
        chk("done_hold_pass", 32'(pass_cnt), 32'd4);

        // Single mismatch on vector 2; go from DONE must clear the previous counts.
        resp[2] = 32'h40400001;
        sb_q.push_back(predict());
        go_pulse();
        wait_done("mismatch");
        chk("mm_ffres_direct", first_fail_result, 32'h40400001);

        // go while busy and a stale done during LAUNCH must both be ignored.
        set_all_pass();
        sb_q.push_back(predict());
        go_pulse();
        wait_launch(1);
        @(negedge clk);
        bist_go = 1'b1;
        @(negedge clk);
        bist_go = 1'b0;
        chk("busy_after_go", 32'(bist_busy), 32'd1);
        wait_launch(2);
        stale = 1'b1;
        @(negedge clk);
        stale = 1'b0;
        wait_done("ignored_inputs");

        // Reset during WAIT of vector 2, then a clean rerun from index 0.
        go_pulse();
        wait_launch(2);
        @(negedge clk);
        chk("pre_rst_pass", 32'(pass_cnt), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid_rst");
        rst = 1'b0;
        sb_q.push_back(predict());
        go_pulse();
        wait_done("rerun");

`ifdef FPU_BIST_TIMEOUT_EN
        hang[1] = 1'b1;
        sb_q.push_back(predict());
        go_pulse();
        wait_done("timeout");
        hang[1] = 1'b0;
`endif

        // Saturation: five passing vectors on 2-bit counters.
        @(negedge clk);
        go2 = 1'b1;
        @(negedge clk);
        go2 = 1'b0;
        for (int n = 0; n < 500 && !done2; n++) @(negedge clk);
        chk("sat_done", 32'(done2), 32'd1);
        chk("sat_pass", 32'(pass2), 32'd3);
        chk("sat_fail", 32'(fail2), 32'd0);
        chk("sat_ffv", 32'(ffv2), 32'd0);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
